negedge_pipe_reg: RTL
=====================

Name: negedge_pipe_reg

Overview:
- Parametrised successor to the single-bit falling-edge D flip-flop cell: a WIDTH-bit, DEPTH-stage pipeline register, clocked on the falling edge of CLK.
- Each stage carries a valid bit and takes part in a valid/ready handshake, so the pipeline can stall, drain and flush.
- Sits at half-cycle clock-domain boundaries: datapaths launched from rising-edge logic and captured mid-cycle, or retimed back.
- Adds reset, enable/stall, flush and an occupancy count, none of which the single-bit cell has.

Parameters:
- WIDTH, 8, data bits per stage (>=1).
- DEPTH, 2, number of falling-edge register stages (>=1).
- CW, $clog2(DEPTH+1), occupancy counter width (derived; not to be overridden).

Ports:
- CLK  in  1  clock; every state element updates on the falling edge only.
- R  in  1  asynchronous, active-low reset; one clock; no other reset.
- FLUSH  in  1  synchronous flush, sampled on the falling edge.
- IN_VALID  in  1  upstream data valid.
- IN_READY  out  1  pipeline can accept D on this falling edge.
- D  in  WIDTH  input data.
- OUT_VALID  out  1  last stage holds valid data.
- OUT_READY  in  1  downstream accepts Q on this falling edge.
- Q  out  WIDTH  last-stage data.
- OCC  out  CW  number of valid stages (0..DEPTH).

Behaviour:
- Reset (R=0, asynchronous, no clock required):
  - All stage data, valid bits and OCC clear to 0.
  - Q=0, OUT_VALID=0, OCC=0.
  - IN_READY=1 while reset is asserted, because it is combinational from the empty state.
  - Deassertion takes effect at the next falling edge.
- Stage state: v[i] and d[i], i = 0..DEPTH-1. Stage 0 is the input side, stage DEPTH-1 drives Q/OUT_VALID.
- Advance chain (combinational, ripple from output side):
  - adv[DEPTH-1] = !v[DEPTH-1] | OUT_READY.
  - adv[i] = !v[i] | adv[i+1].
  - IN_READY = adv[0].
  - No combinational path from D to Q. The OUT_READY→IN_READY path is combinational and documented.
- On each falling edge with R=1 and FLUSH=0:
  - Stage i with adv[i]=1 loads from stage i-1 (stage 0 loads IN_VALID/D).
  - Stage i with adv[i]=0 holds.
  - Data registers load only when the incoming valid=1, which saves power; stale data under v=0 is don't-care but must not reach Q as valid.
- Transfers:
  - Input transfer = IN_VALID & IN_READY at the falling edge.
  - Output transfer = OUT_VALID & OUT_READY at the falling edge.
- Latency: DEPTH falling edges from input transfer to OUT_VALID=1, when unstalled. Throughput: one word per falling edge.
- Full: OCC=DEPTH and OUT_READY=0 gives IN_READY=0; IN_VALID is ignored and no word is dropped or overwritten.
- Full with OUT_READY=1: simultaneous input and output transfer; OCC unchanged.
- Empty: OUT_VALID=0 and Q holds its last value. The bench checks Q only when OUT_VALID=1.
- OCC update: OCC_next = OCC + in_xfer − out_xfer. It never wraps and saturates at the structural bounds 0..DEPTH; an assertion flags violation.
- FLUSH=1 at a falling edge:
  - All v clear and OCC becomes 0.
  - It overrides a simultaneous input transfer: the word presented that edge is discarded.
  - A simultaneous output transfer still counts as consumed (downstream saw OUT_VALID).
- Reset mid-stream: in-flight words are lost immediately (async), with no partial output.
- Rising edges of CLK have no effect on state.
- X on IN_VALID or OUT_READY while R=1 fires a simulation assertion.

Decomposition:
- Shared package negedge_pipe_pkg holds:
  - The CW derivation function.
  - A localparam for minimum DEPTH/WIDTH.
  - A stage struct typedef (valid + data) used by the bench scoreboard.
- One sub-module: negedge_pipe_stage. It is one valid+data register on the falling edge with async active-low reset and a load enable, instantiated DEPTH times in a generate loop.
- The top holds the advance chain, flush and OCC.

Test Plan:
- Reset: hold R=0, then toggle CLK. Expect Q=0, OUT_VALID=0, OCC=0, IN_READY=1 before any edge. After R rises, the first falling edge with IN_VALID=1, D=8'hA5 gives OCC=1.
- Streaming (WIDTH=8, DEPTH=2, OUT_READY=1): drive D=1,2,3,… on consecutive falling edges. Q=1 appears with OUT_VALID=1 after 2 falling edges, then one word per edge in order; OCC steady at 2.
- Backpressure: OUT_READY=0 with 3 words offered. OCC reaches 2 and IN_READY=0; the third word is held upstream. Raising OUT_READY releases words 1,2,3 in order with no loss or duplication.
- Full with simultaneous transfer: OCC=2, OUT_READY=1, IN_VALID=1, D=8'h3C. Output transfer and input transfer occur on the same edge; OCC stays 2 and 8'h3C emerges 2 edges later.
- Flush: OCC=2, assert FLUSH with IN_VALID=1, D=8'hFF for one falling edge. Next OCC=0 and OUT_VALID=0; 8'hFF never appears on Q.
- Async reset mid-stream: OCC=2, pulse R low between edges. OUT_VALID and OCC drop to 0 immediately, without a clock edge. DEPTH=1 and DEPTH=4 regressions repeat the streaming and backpressure scenarios.

Source files
------------

// File: rtl/negedge_pipe_pkg.sv
// Shared definitions for the falling-edge pipeline register: size limits,
// occupancy-width derivation and the stage record used by checkers.
package negedge_pipe_pkg;

    localparam int MIN_DEPTH = 1;
    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 64;

    // Counter must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic                 vld;
        logic [MAX_WIDTH-1:0] dat;
    } stage_t;

endpackage

// File: rtl/negedge_pipe_stage.sv
// One valid+data register on the falling edge of CLK; loads when load=1.
// Data only captures valid words, so bubbles do not toggle the data flops.
module negedge_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             flush,
    input  logic             load,
    input  logic             nxt_vld,
    input  logic [WIDTH-1:0] nxt_dat,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);

    always_ff @(negedge CLK or negedge R) begin
        if (!R) begin
            vld <= 1'b0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= nxt_vld;
        end
    end

    always_ff @(negedge CLK or negedge R) begin
        if (!R) begin
            dat <= '0;
        end else if (load && nxt_vld && !flush) begin
            dat <= nxt_dat;
        end
    end

endmodule

// File: rtl/negedge_pipe_reg.sv
// WIDTH x DEPTH falling-edge pipeline with valid/ready, flush and occupancy; DEPTH edges latency.
// Stalls ripple from OUT_READY back to IN_READY combinationally; a full, stalled pipe refuses input.
module negedge_pipe_reg
    import negedge_pipe_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int CW    = occ_width(DEPTH)
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] D,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Q,
    output logic [CW-1:0]    OCC
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic             in_xfer;
    logic             out_xfer;
    logic [CW-1:0]    occ_q;
    logic [CW-1:0]    occ_nxt;

    // A stage may advance when any stage at or beyond it is empty, or the output drains.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            adv[i] = OUT_READY;
            for (int j = i; j < DEPTH; j++) begin
                if (!v[j]) begin
                    adv[i] = 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             lv;
        logic [WIDTH-1:0] ld;

        if (i == 0) begin : g_head
            assign lv = IN_VALID;
            assign ld = D;
        end else begin : g_body
            assign lv = v[i-1];
            assign ld = d[i-1];
        end

        negedge_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .CLK     (CLK),
            .R       (R),
            .flush   (FLUSH),
            .load    (adv[i]),
            .nxt_vld (lv),
            .nxt_dat (ld),
            .vld     (v[i]),
            .dat     (d[i])
        );
    end

    assign IN_READY  = adv[0];
    assign OUT_VALID = v[DEPTH-1];
    assign Q         = d[DEPTH-1];
    assign OCC       = occ_q;

    assign in_xfer  = IN_VALID & IN_READY;
    assign out_xfer = OUT_VALID & OUT_READY;

    always_comb begin
        occ_nxt = occ_q;
        if (FLUSH) begin
            occ_nxt = '0;
        end else if (in_xfer && !out_xfer && occ_q != CW'(DEPTH)) begin
            occ_nxt = occ_q + 1'b1;
        end else if (!in_xfer && out_xfer && occ_q != '0) begin
            occ_nxt = occ_q - 1'b1;
        end
    end

    always_ff @(negedge CLK or negedge R) begin
        if (!R) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_nxt;
        end
    end

    a_ctrl_known: assert property (@(negedge CLK) disable iff (!R)
        !$isunknown({IN_VALID, OUT_READY}));

    // The counter is a shadow of the valid bits; any divergence means a lost or invented word.
    a_occ_bounds: assert property (@(negedge CLK) disable iff (!R)
        (int'(occ_q) <= DEPTH) && (int'(occ_q) == $countones(v)));

endmodule
